// File: rtl/m_eth_pkg.sv
// Shared types and constants for the MII receive path: FSM states, CRC-32 constants and
// the nibble-wide CRC update used by the receive checker.
package m_eth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StDrop
    } rx_state_e;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [3:0]  PRE_NIB     = 4'h5;
    localparam logic [3:0]  SFD_NIB     = 4'hD;

    // Bits enter in wire order (data[0] first); the register is kept un-reflected.
    function automatic logic [31:0] crc_nib_next(input logic [31:0] crc, input logic [3:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/m_rx_crc_nib.sv
// Nibble-wide IEEE 802.3 CRC-32 engine; one MII nibble per enabled cycle.
module m_rx_crc_nib
    import m_eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Init,
    input  logic        Enable,
    input  logic [3:0]  Data,
    output logic [31:0] Crc
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Crc <= CRC_INIT;
        end else if (Init) begin
            Crc <= CRC_INIT;
        end else if (Enable) begin
            Crc <= crc_nib_next(Crc, Data);
        end
    end

endmodule

// File: rtl/m_rx_crc_check.sv
// MII receive frame checker: strips preamble/SFD, assembles bytes, checks FCS and reports status.
// Optional M_RX_CRC_STRIP_EN hides the 4 FCS bytes behind a 4-byte delay line.
module m_rx_crc_check
    import m_eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  MRxD,
    input  logic        MRxDV,
    input  logic        MRxErr,
    output logic [7:0]  RxData,
    output logic        RxDataValid,
    output logic        RxSof,
    output logic        RxEof,
    output logic        RxCrcErr,
    output logic        RxDribble,
    output logic        RxPhyErr,
    output logic        RxShort,
    output logic        RxLong,
    output logic [10:0] RxByteCnt
);

    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);

    rx_state_e   state_q, state_d;
    logic        crc_init, crc_en;
    logic [31:0] crc;
    logic        nib_odd_q;
    logic [3:0]  low_nib_q;
    logic [10:0] byte_cnt_q;
    logic        phy_err_q;
    logic        first_q;
    logic        byte_done, emit;
    logic [7:0]  new_byte, out_byte;

    m_rx_crc_nib u_crc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Init    (crc_init),
        .Enable  (crc_en),
        .Data    (MRxD),
        .Crc     (crc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MRxDV) begin
                    state_d = (MRxD == PRE_NIB) ? StPreamble : StDrop;
                end
            end
            StPreamble: begin
                if (!MRxDV) begin
                    state_d = StIdle;
                end else if (MRxD == SFD_NIB) begin
                    state_d  = StData;
                    crc_init = 1'b1;
                end else if (MRxD != PRE_NIB) begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (MRxDV) begin
                    crc_en = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (!MRxDV) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_done = (state_q == StData) && MRxDV && nib_odd_q;
    assign new_byte  = {MRxD, low_nib_q};
    assign RxByteCnt = byte_cnt_q;

`ifdef M_RX_CRC_STRIP_EN
    logic [3:0][7:0] dly_q;
    logic [2:0]      fill_q;

    // A byte leaves only once four newer bytes exist, so the trailing FCS never emerges.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dly_q  <= '0;
            fill_q <= 3'd0;
        end else if (crc_init) begin
            fill_q <= 3'd0;
        end else if (byte_done) begin
            dly_q <= {dly_q[2:0], new_byte};
            if (fill_q != 3'd4) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end

    assign emit     = byte_done && (fill_q == 3'd4);
    assign out_byte = dly_q[3];
`else
    assign emit     = byte_done;
    assign out_byte = new_byte;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nib_odd_q   <= 1'b0;
            low_nib_q   <= 4'h0;
            byte_cnt_q  <= 11'd0;
            phy_err_q   <= 1'b0;
            first_q     <= 1'b0;
            RxData      <= 8'h00;
            RxDataValid <= 1'b0;
            RxSof       <= 1'b0;
            RxEof       <= 1'b0;
            RxCrcErr    <= 1'b0;
            RxDribble   <= 1'b0;
            RxPhyErr    <= 1'b0;
            RxShort     <= 1'b0;
            RxLong      <= 1'b0;
        end else begin
            RxDataValid <= 1'b0;
            RxSof       <= 1'b0;
            RxEof       <= 1'b0;
            if (crc_init) begin
                nib_odd_q  <= 1'b0;
                byte_cnt_q <= 11'd0;
                phy_err_q  <= 1'b0;
                first_q    <= 1'b1;
            end
            if (state_q == StData) begin
                if (MRxDV) begin
                    phy_err_q <= phy_err_q | MRxErr;
                    nib_odd_q <= ~nib_odd_q;
                    if (!nib_odd_q) begin
                        low_nib_q <= MRxD;
                    end else if (byte_cnt_q != 11'h7FF) begin
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                    end
                end else begin
                    RxEof     <= 1'b1;
                    RxCrcErr  <= (crc != CRC_RESIDUE);
                    RxDribble <= nib_odd_q;
                    RxPhyErr  <= phy_err_q;
                    RxShort   <= (byte_cnt_q < MIN_CNT);
                    RxLong    <= (byte_cnt_q > MAX_CNT);
                end
            end
            if (emit) begin
                RxData      <= out_byte;
                RxDataValid <= 1'b1;
                RxSof       <= first_q;
                first_q     <= 1'b0;
                // Previous frame's status stays visible until the new frame's first byte.
                if (first_q) begin
                    RxCrcErr  <= 1'b0;
                    RxDribble <= 1'b0;
                    RxPhyErr  <= 1'b0;
                    RxShort   <= 1'b0;
                    RxLong    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_rx_crc_check.sv
// Self-checking bench for m_rx_crc_check: directed MII frames against a reflected-CRC byte model.
module tb_m_rx_crc_check;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [3:0] nib_q_t[$];
    typedef struct {
        logic [7:0] d;
        logic       s;
    } exp_byte_t;
    typedef struct {
        logic [10:0] cnt;
        logic [4:0]  st;  // {crc, dribble, phy, short, long}
    } exp_eof_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  MRxD = 4'h0;
    logic        MRxDV = 1'b0;
    logic        MRxErr = 1'b0;
    logic [7:0]  RxData;
    logic        RxDataValid, RxSof, RxEof;
    logic        RxCrcErr, RxDribble, RxPhyErr, RxShort, RxLong;
    logic [10:0] RxByteCnt;

    int checks = 0;
    int failures = 0;
    int n_strobes = 0;
    int n_eof = 0;
    logic [10:0] last_cnt = '0;
    logic [4:0]  last_st = '0;
    logic [4:0]  held = '0;
    exp_byte_t   exp_bytes[$];
    exp_eof_t    exp_eofs[$];

    m_rx_crc_check dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .MRxD        (MRxD),
        .MRxDV       (MRxDV),
        .MRxErr      (MRxErr),
        .RxData      (RxData),
        .RxDataValid (RxDataValid),
        .RxSof       (RxSof),
        .RxEof       (RxEof),
        .RxCrcErr    (RxCrcErr),
        .RxDribble   (RxDribble),
        .RxPhyErr    (RxPhyErr),
        .RxShort     (RxShort),
        .RxLong      (RxLong),
        .RxByteCnt   (RxByteCnt)
    );

    always #20 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reflected LSB-first CRC-32 over the wire bit stream; a good frame leaves 32'hDEBB20E3.
    function automatic logic [31:0] crc_refl(input nib_q_t nq);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (nq[k]) begin
            for (int b = 0; b < 4; b++) begin
                if (r[0] ^ nq[k][b]) r = (r >> 1) ^ 32'hEDB88320;
                else r = r >> 1;
            end
        end
        return r;
    endfunction

    function automatic nib_q_t to_nibs(input byte_q_t bq);
        nib_q_t nq;
        foreach (bq[k]) begin
            nq.push_back(bq[k][3:0]);
            nq.push_back(bq[k][7:4]);
        end
        return nq;
    endfunction

    task automatic nib(input logic [3:0] d, input logic dv, input logic er);
        MRxD = d;
        MRxDV = dv;
        MRxErr = er;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input int nbytes, input bit flip, input bit drib, input int err_nib,
                              input int gap, input int abort_byte);
        byte_q_t     fr;
        nib_q_t      nq;
        logic [31:0] fcs;
        int          n_out;
        exp_byte_t   eb;
        exp_eof_t    ee;
        if (nbytes >= 4) begin
            for (int i = 0; i < nbytes - 4; i++)
                fr.push_back(abort_byte > 0 ? 8'hA3 : 8'(i * 37 + 11));
            fcs = ~crc_refl(to_nibs(fr));
            for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
        end else begin
            for (int i = 0; i < nbytes; i++) fr.push_back(8'(i + 1));
        end
        if (flip) fr[10] = fr[10] ^ 8'h08;
        nq = to_nibs(fr);
        if (drib) nq.push_back(4'h6);
        n_out = (abort_byte > 0) ? abort_byte : nbytes;
`ifdef M_RX_CRC_STRIP_EN
        n_out = n_out - 4;
`endif
        for (int i = 0; i < n_out; i++) begin
            eb.d = fr[i];
            eb.s = (i == 0);
            exp_bytes.push_back(eb);
        end
        if (abort_byte == 0) begin
            ee.cnt = (nbytes > 2047) ? 11'd2047 : 11'(nbytes);
            ee.st  = {crc_refl(nq) != 32'hDEBB20E3, drib,
                      (err_nib >= 0) && (err_nib < nq.size()), nbytes < 64, nbytes > 1518};
            exp_eofs.push_back(ee);
        end
        repeat (7) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        foreach (nq[i]) begin
            nib(nq[i], 1'b1, i == err_nib);
            if (abort_byte > 0 && i == 2 * abort_byte) Reset_n = 1'b0;
            if (abort_byte > 0 && i == 2 * abort_byte + 3) Reset_n = 1'b1;
        end
        repeat (gap) nib(4'h0, 1'b0, 1'b0);
    endtask

    always @(negedge Clk) begin
        exp_byte_t eb;
        exp_eof_t  ee;
        if (!Reset_n) begin
            held = '0;
        end else begin
            if (RxDataValid) begin
                n_strobes++;
                check("byte_expected", exp_bytes.size() != 0, 1);
                if (exp_bytes.size() != 0) begin
                    eb = exp_bytes.pop_front();
                    check("rx_data", RxData, eb.d);
                    check("rx_sof", RxSof, eb.s);
                end
                if (RxSof) held = '0;
            end else if (RxSof) begin
                check("sof_without_valid", RxSof, 0);
            end
            if (RxEof) begin
                n_eof++;
                last_cnt = RxByteCnt;
                last_st = {RxCrcErr, RxDribble, RxPhyErr, RxShort, RxLong};
                check("eof_expected", exp_eofs.size() != 0, 1);
                if (exp_eofs.size() != 0) begin
                    ee = exp_eofs.pop_front();
                    check("eof_byte_cnt", RxByteCnt, ee.cnt);
                    held = ee.st;
                end
            end
            check("status_held", {RxCrcErr, RxDribble, RxPhyErr, RxShort, RxLong}, held);
        end
    end

    initial begin
        byte_q_t s;
        int      s0, e0;
        int      good_strobes;
`ifdef M_RX_CRC_STRIP_EN
        good_strobes = 60;
`else
        good_strobes = 64;
`endif
        repeat (3) @(posedge Clk);
        #1;
        check("reset_valid", RxDataValid, 0);
        check("reset_sof", RxSof, 0);
        check("reset_eof", RxEof, 0);
        check("reset_status", {RxCrcErr, RxDribble, RxPhyErr, RxShort, RxLong}, 0);
        check("reset_cnt", RxByteCnt, 0);
        check("reset_data", RxData, 0);
        Reset_n = 1'b1;
        repeat (2) nib(4'h0, 1'b0, 1'b0);

        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_123456789", ~crc_refl(to_nibs(s)), 32'hCBF43926);

        s0 = n_strobes;
        send_frame(64, 0, 0, -1, 3, 0);
        check("good_strobes", n_strobes - s0, good_strobes);
        check("good_cnt", last_cnt, 64);
        check("good_status", last_st, 5'b00000);

        send_frame(64, 1, 0, -1, 3, 0);
        check("flip_status", last_st, 5'b10000);

        // Back-to-back: next preamble right after the single low cycle
        e0 = n_eof;
        send_frame(64, 0, 0, -1, 1, 0);
        send_frame(64, 0, 0, -1, 3, 0);
        check("b2b_eofs", n_eof - e0, 2);
        check("b2b_status", last_st, 5'b00000);

        send_frame(64, 0, 1, -1, 3, 0);
        check("dribble_cnt", last_cnt, 64);
        check("dribble_bit", last_st[3], 1);

        send_frame(40, 0, 0, -1, 3, 0);
        check("short_status", last_st, 5'b00010);
        send_frame(1519, 0, 0, -1, 3, 0);
        check("long_status", last_st, 5'b00001);
        check("long_cnt", last_cnt, 1519);

        send_frame(0, 0, 0, -1, 3, 0);
        check("empty_status", last_st, 5'b10010);

        s0 = n_strobes;
        e0 = n_eof;
        foreach (s[i]) s[i] = 8'h00;
        nib(4'h5, 1, 0); nib(4'h5, 1, 0); nib(4'h5, 1, 0); nib(4'h7, 1, 0);
        nib(4'h5, 1, 0); nib(4'h5, 1, 0); nib(4'hD, 1, 0); nib(4'h1, 1, 0);
        nib(4'h2, 1, 0); nib(4'h3, 1, 0);
        repeat (3) nib(4'h0, 0, 0);
        repeat (3) nib(4'h5, 1, 0);
        repeat (3) nib(4'h0, 0, 0);
        check("drop_strobes", n_strobes - s0, 0);
        check("drop_eofs", n_eof - e0, 0);

        send_frame(64, 0, 0, 20, 3, 0);
        check("phyerr_status", last_st, 5'b00100);

        e0 = n_eof;
        send_frame(64, 0, 0, -1, 3, 30);
        check("abort_no_eof", n_eof - e0, 0);
        s0 = n_strobes;
        send_frame(64, 0, 0, -1, 3, 0);
        check("after_abort_strobes", n_strobes - s0, good_strobes);
        check("after_abort_status", last_st, 5'b00000);
        check("after_abort_eofs", n_eof - e0, 1);

        repeat (4) nib(4'h0, 0, 0);
        check("bytes_left", exp_bytes.size(), 0);
        check("eofs_left", exp_eofs.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
